// File: rtl/macc_pkg.sv
// Shared definitions for the macc output stage.
// Purpose: default widths for the accumulator output path plus helpers that
// give the saturation limits of a signed word and the round-half-up constant
// added before an arithmetic right shift.
// Port summary: none (package).
package macc_pkg;

  localparam int SIZEIN_DEF   = 40;
  localparam int SIZEOUT_DEF  = 16;
  localparam int SHIFT_DEF    = 15;
  localparam int SATCNT_W_DEF = 16;

  // Largest value of a w-bit two's complement word, 2^(w-1)-1.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value of a w-bit two's complement word, -2^(w-1).
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Half an LSB of the shifted result, so that a following arithmetic shift
  // rounds half-up (toward +inf). A zero shift drops no bits and adds nothing.
  function automatic logic signed [63:0] round_const(input int shift);
    if (shift > 0) begin
      return 64'sd1 <<< (shift - 1);
    end
    return 64'sd0;
  endfunction

endpackage

// File: rtl/macc_sat_clamp.sv
// Combinational clamp of a rounded value into a narrow signed word.
// Purpose: given the rounded/shifted value plus the accumulator overflow flag
// and the accumulator sign bit, produce the output word and a flag telling
// whether clamping took place.
// Ports:
//   i_rnd   RW-bit signed rounded value
//   i_ovf   accumulator overflowed; the sign bit then points the wrong way
//   i_msb   sign bit of the original accumulator value
//   o_data  OW-bit signed clamped result
//   o_sat   result was clamped to a limit
module macc_sat_clamp
  import macc_pkg::*;
#(
  parameter int RW = SIZEIN_DEF + 1,
  parameter int OW = SIZEOUT_DEF
) (
  input  logic signed [RW-1:0] i_rnd,
  input  logic                 i_ovf,
  input  logic                 i_msb,
  output logic        [OW-1:0] o_data,
  output logic                 o_sat
);

  localparam logic signed [63:0]   MAX64 = sat_max(OW);
  localparam logic signed [63:0]   MIN64 = sat_min(OW);
  localparam logic signed [RW-1:0] MAXV  = MAX64[RW-1:0];
  localparam logic signed [RW-1:0] MINV  = MIN64[RW-1:0];
  localparam logic        [OW-1:0] MAXO  = MAX64[OW-1:0];
  localparam logic        [OW-1:0] MINO  = MIN64[OW-1:0];

  // An overflowed accumulator has wrapped, so its sign bit reads inverted:
  // a negative-looking value really overflowed upward and goes to +MAX.
  // Otherwise compare the widened rounded value against the output limits.
  always_comb begin
    o_data = i_rnd[OW-1:0];
    o_sat  = 1'b0;
    if (i_ovf) begin
      o_data = i_msb ? MAXO : MINO;
      o_sat  = 1'b1;
    end else if (i_rnd > MAXV) begin
      o_data = MAXO;
      o_sat  = 1'b1;
    end else if (i_rnd < MINV) begin
      o_data = MINO;
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/macc_round_sat.sv
// Output stage behind the multiply-accumulator.
// Purpose: two-stage elastic pipeline that rounds (half-up), shifts and
// saturates a wide signed accumulator value into a narrow signed word, with a
// sticky overflow flag and a saturating count of clamped output beats.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ce             clock enable, low freezes every pipeline/counter register
//   accum_in       signed accumulator value
//   acc_overflow   overflow flag travelling with accum_in
//   in_valid       input beat valid
//   in_ready       stage accepts an input beat this cycle
//   data_out       rounded/saturated result
//   sat            data_out was clamped
//   out_valid      data_out valid
//   out_ready      downstream accepts data_out
//   sticky_ovf     an accepted beat carried acc_overflow
//   clr_sticky     clears sticky_ovf (works even while ce is low)
//   sat_count      number of transferred clamped beats, saturating
module macc_round_sat
  import macc_pkg::*;
#(
  parameter int SIZEIN   = SIZEIN_DEF,
  parameter int SIZEOUT  = SIZEOUT_DEF,
  parameter int SHIFT    = SHIFT_DEF,
  parameter int SATCNT_W = SATCNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [SIZEIN-1:0]   accum_in,
  input  logic                acc_overflow,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SIZEOUT-1:0]  data_out,
  output logic                sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sticky_ovf,
  input  logic                clr_sticky,
  output logic [SATCNT_W-1:0] sat_count
);

  localparam logic signed [63:0]     RND64 = round_const(SHIFT);
  localparam logic signed [SIZEIN:0] RND_C = RND64[SIZEIN:0];

  logic                       w_en;
  logic                       w_inXfer;
  logic                       w_outXfer;
  logic signed [SIZEIN:0]     w_ext;
  logic signed [SIZEIN:0]     w_sum;
  logic signed [SIZEIN:0]     w_rnd;
  logic        [SIZEOUT-1:0] w_clampData;
  logic                       w_clampSat;

  logic                       r_s1Valid;
  logic signed [SIZEIN:0]     r_s1Rnd;
  logic                       r_s1Ovf;
  logic                       r_s1Msb;
  logic                       r_outValid;
  logic        [SIZEOUT-1:0] r_dataOut;
  logic                       r_sat;
  logic                       r_stickyOvf;
  logic        [SATCNT_W-1:0] r_satCount;

  // Both stages advance together whenever the output register is empty or
  // being drained, so a stall at the output holds the whole pipe.
  assign w_en      = ce & (~r_outValid | out_ready);
  assign in_ready  = w_en;
  assign w_inXfer  = in_valid & w_en;
  assign w_outXfer = ce & r_outValid & out_ready;

  // One extra bit of headroom keeps the half-LSB add from wrapping at the
  // top of the accumulator range before the arithmetic shift.
  assign w_ext = {accum_in[SIZEIN-1], accum_in};
  assign w_sum = w_ext + RND_C;
  assign w_rnd = w_sum >>> SHIFT;

  // Stage 1 captures the rounded value with the flags the clamp needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Rnd   <= '0;
      r_s1Ovf   <= 1'b0;
      r_s1Msb   <= 1'b0;
    end else if (w_en) begin
      r_s1Valid <= in_valid;
      r_s1Rnd   <= w_rnd;
      r_s1Ovf   <= acc_overflow;
      r_s1Msb   <= accum_in[SIZEIN-1];
    end
  end

  macc_sat_clamp #(
    .RW (SIZEIN + 1),
    .OW (SIZEOUT)
  ) u_clamp (
    .i_rnd  (r_s1Rnd),
    .i_ovf  (r_s1Ovf),
    .i_msb  (r_s1Msb),
    .o_data (w_clampData),
    .o_sat  (w_clampSat)
  );

  // Stage 2 registers the clamped word so the outputs stay stable under
  // backpressure and carry no combinational path from the clamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_dataOut  <= '0;
      r_sat      <= 1'b0;
    end else if (w_en) begin
      r_outValid <= r_s1Valid;
      r_dataOut  <= w_clampData;
      r_sat      <= w_clampSat;
    end
  end

  // The sticky flag ignores ce for clearing so software can always drop it;
  // a new overflowed beat in the same cycle takes priority over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stickyOvf <= 1'b0;
    end else if (w_inXfer & acc_overflow) begin
      r_stickyOvf <= 1'b1;
    end else if (clr_sticky) begin
      r_stickyOvf <= 1'b0;
    end
  end

  // Count clamped beats actually handed downstream; stop at all-ones rather
  // than wrap so a long run of clamps never reads back as a small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_satCount <= '0;
    end else if (w_outXfer & r_sat & ~(&r_satCount)) begin
      r_satCount <= r_satCount + SATCNT_W'(1);
    end
  end

  assign out_valid  = r_outValid;
  assign data_out   = r_dataOut;
  assign sat        = r_sat;
  assign sticky_ovf = r_stickyOvf;
  assign sat_count  = r_satCount;

endmodule
